// File: rtl/data_mem_lsu_if.sv
// Load/store bundle: pipeline request/response plus both data-memory ports.
// The master modport is the LSU side (it initiates memory traffic), slave is
// the pipeline/memory environment around it.
interface data_mem_lsu_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic              mem_ena;
  logic [3:0]        mem_wea;
  logic [ADDR_W-1:0] mem_addrb;
  logic              mem_enb;
  logic [DATA_W-1:0] mem_doutb;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_doutb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addra, mem_dina, mem_ena, mem_wea, mem_addrb, mem_enb
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_doutb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addra, mem_dina, mem_ena, mem_wea, mem_addrb, mem_enb
  );
endinterface

// File: rtl/data_mem_lsu.sv
// RV32I load/store unit in front of a dual-port word-addressed data memory.
// One access at a time; sub-word stores are done as read-merge-write so the
// memory only ever sees full-word writes. All outputs are registered.
module data_mem_lsu #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  data_mem_lsu_if.master bus
);

  typedef enum logic [2:0] {StIdle, StRd, StMerge, StLdfmt, StWr, StResp} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wdata_q;

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              mem_ena_q;
  logic              mem_enb_q;
  logic [3:0]        mem_wea_q;
  logic [ADDR_W-1:0] mem_addra_q;
  logic [ADDR_W-1:0] mem_addrb_q;
  logic [DATA_W-1:0] mem_dina_q;

  logic              req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] ld_fmt;
  logic [DATA_W-1:0] st_merge;

  // Address bits above the memory size wrap, so they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // Illegal funct3 or misalignment of the request currently offered.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_we) begin
      case (bus.req_funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = bus.req_addr[0];
        3'b010:  req_err = |bus.req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = bus.req_addr[0];
        3'b010:         req_err = |bus.req_addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end
  end

  // Lane select and sign/zero extension of the word read back from port B.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_doutb[7:0];
      2'd1:    lane_b = bus.mem_doutb[15:8];
      2'd2:    lane_b = bus.mem_doutb[23:16];
      default: lane_b = bus.mem_doutb[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_doutb[31:16] : bus.mem_doutb[15:0];
    case (funct3_q)
      3'b000:  ld_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_fmt = {24'b0, lane_b};
      3'b101:  ld_fmt = {16'b0, lane_h};
      default: ld_fmt = bus.mem_doutb;
    endcase
  end

  // Overlay the store byte/half onto the old word for the full-word write.
  always_comb begin
    st_merge = bus.mem_doutb;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    st_merge[7:0]   = wdata_q[7:0];
        2'd1:    st_merge[15:8]  = wdata_q[7:0];
        2'd2:    st_merge[23:16] = wdata_q[7:0];
        default: st_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merge[31:16] = wdata_q;
    end else begin
      st_merge[15:0] = wdata_q;
    end
  end

  // Access sequencer; every output is set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_ena_q    <= 1'b0;
      mem_enb_q    <= 1'b0;
      mem_wea_q    <= 4'b0000;
      mem_addra_q  <= '0;
      mem_addrb_q  <= '0;
      mem_dina_q   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr[ADDR_W+1:0];
            wdata_q  <= bus.req_wdata[15:0];
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state        <= StResp;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              mem_ena_q   <= 1'b1;
              mem_wea_q   <= 4'b1111;
              mem_addra_q <= bus.req_addr[ADDR_W+1:2];
              mem_dina_q  <= bus.req_wdata;
              state       <= StWr;
            end else begin
              // Loads and sub-word stores both start with a read of the word.
              mem_enb_q   <= 1'b1;
              mem_addrb_q <= bus.req_addr[ADDR_W+1:2];
              state       <= StRd;
            end
          end
        end
        StRd: begin
          mem_enb_q <= 1'b0;
          state     <= we_q ? StMerge : StLdfmt;
        end
        StMerge: begin
          mem_ena_q   <= 1'b1;
          mem_wea_q   <= 4'b1111;
          mem_addra_q <= addr_q[ADDR_W+1:2];
          mem_dina_q  <= st_merge;
          state       <= StWr;
        end
        StLdfmt: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ld_fmt;
          resp_err_q   <= 1'b0;
          state        <= StResp;
        end
        StWr: begin
          mem_ena_q    <= 1'b0;
          mem_wea_q    <= 4'b0000;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          state        <= StResp;
        end
        StResp: begin
          resp_valid_q <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Enables are masked by rst so no memory access can happen during reset.
  assign bus.req_ready  = (state == StIdle) && !rst;
  assign bus.resp_valid = resp_valid_q && !rst;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_ena    = mem_ena_q && !rst;
  assign bus.mem_enb    = mem_enb_q && !rst;
  assign bus.mem_wea    = rst ? 4'b0000 : mem_wea_q;
  assign bus.mem_addra  = mem_addra_q;
  assign bus.mem_addrb  = mem_addrb_q;
  assign bus.mem_dina   = mem_dina_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a behavioural dual-port memory and a
// scoreboard of expected responses.
module tb_data_mem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_lsu_if #(.ADDR_W(15), .DATA_W(32)) bus();

  data_mem_lsu #(.ADDR_W(15), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural memory: byte-enabled write port A, 1-cycle read port B.
  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (bus.mem_ena) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wea[b]) mem[bus.mem_addra][8*b +: 8] <= bus.mem_dina[8*b +: 8];
      end
    end
    if (bus.mem_enb) bus.mem_doutb <= mem[bus.mem_addrb];
  end

  // Activity monitor sampled mid-cycle.
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          resp_cnt = 0;
  int          clash_cnt = 0;
  logic [14:0] last_addra = '0;
  logic [31:0] last_dina = '0;
  logic [3:0]  last_wea = '0;
  always @(negedge clk) begin
    if (bus.mem_ena) begin
      wr_cnt++;
      last_addra = bus.mem_addra;
      last_dina  = bus.mem_dina;
      last_wea   = bus.mem_wea;
    end
    if (bus.mem_enb) rd_cnt++;
    if (bus.mem_ena && bus.mem_enb) clash_cnt++;
    if (bus.resp_valid) resp_cnt++;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          rd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction: push expectation, drive, wait for response, compare.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_wr, input int exp_rd);
    exp_t e;
    int   n;
    int   w0;
    int   r0;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, {31'b0, bus.req_ready}, 32'd1);
    w0 = wr_cnt;
    r0 = rd_cnt;
    sb.push_back('{exp_rdata, exp_err, exp_lat, exp_wr, exp_rd});
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // Garbage after accept must not affect the latched request.
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h0;
      end
    end while (!bus.resp_valid && n < 12);
    #1;
    e = sb.pop_front();
    chk({tag, " latency"}, n, e.lat);
    chk({tag, " rdata"}, bus.resp_rdata, e.rdata);
    chk({tag, " err"}, {31'b0, bus.resp_err}, {31'b0, e.err});
    chk({tag, " writes"}, wr_cnt - w0, e.wr);
    chk({tag, " reads"}, rd_cnt - r0, e.rd);
  endtask

  initial begin
    int w0;
    int q0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset held with a request pending.
    repeat (3) begin
      @(negedge clk);
      chk("rst ready", {31'b0, bus.req_ready}, 32'd0);
      chk("rst ena", {31'b0, bus.mem_ena}, 32'd0);
      chk("rst enb", {31'b0, bus.mem_enb}, 32'd0);
      chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst rdata", bus.resp_rdata, 32'd0);
      chk("rst err", {31'b0, bus.resp_err}, 32'd0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", {31'b0, bus.req_ready}, 32'd1);

    // SW then LW.
    xact("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
    chk("sw addra", {17'b0, last_addra}, 32'd4);
    chk("sw wea", {28'b0, last_wea}, 32'hF);
    chk("sw dina", last_dina, 32'hDEADBEEF);
    xact("lw", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 1);
    @(negedge clk);
    chk("resp pulse", {31'b0, bus.resp_valid}, 32'd0);
    chk("rdata hold", bus.resp_rdata, 32'hDEADBEEF);

    // Sub-word stores merged over DEADBEEF.
    xact("sb", 1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 4, 1, 1);
    chk("sb dina", last_dina, 32'hDEAD5AEF);
    chk("sb wea", {28'b0, last_wea}, 32'hF);
    xact("sh", 1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h0, 1'b0, 4, 1, 1);
    chk("sh dina", last_dina, 32'h12345AEF);
    xact("lw merged", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12345AEF, 1'b0, 3, 0, 1);

    // Load extension on 12345AEF.
    xact("lb", 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 3, 0, 1);
    xact("lbu", 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0, 3, 0, 1);
    xact("lh hi", 1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0, 3, 0, 1);
    xact("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 32'h00005AEF, 1'b0, 3, 0, 1);
    xact("lb 1", 1'b0, 3'b000, 32'h11, 32'h0, 32'h0000005A, 1'b0, 3, 0, 1);
    xact("lb 3", 1'b0, 3'b000, 32'h13, 32'h0, 32'h00000012, 1'b0, 3, 0, 1);
    xact("lh lo", 1'b0, 3'b001, 32'h10, 32'h0, 32'h00005AEF, 1'b0, 3, 0, 1);

    // Upper address bits alias onto the same word.
    xact("sw wrap", 1'b1, 3'b010, 32'h0002_0014, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 0);
    chk("wrap addra", {17'b0, last_addra}, 32'd5);
    xact("lw wrap", 1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0, 1);

    // Errors: no memory traffic, response the cycle after accept.
    xact("err lw", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    xact("err sh", 1'b1, 3'b001, 32'h13, 32'h5555, 32'h0, 1'b1, 1, 0, 0);
    xact("err f3 ld", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    xact("err f3 st", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    xact("err lh", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0);

    // Reset during the MERGE cycle of an SB aborts it.
    @(negedge clk);
    chk("abort ready", {31'b0, bus.req_ready}, 32'd1);
    w0 = wr_cnt;
    q0 = resp_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort ena", {31'b0, bus.mem_ena}, 32'd0);
    chk("abort ready low", {31'b0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort writes", wr_cnt - w0, 32'd0);
    chk("abort resps", resp_cnt - q0, 32'd0);
    xact("lw after abort", 1'b0, 3'b010, 32'h10, 32'h0, 32'h12345AEF, 1'b0, 3, 0, 1);

    chk("port clash", clash_cnt, 32'd0);
    chk("scoreboard empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store initiator sitting between the pipeline MEM stage and the dual-port word-addressed data memory. The memory has a write port A (addra/dina/ena/wea) and a read port B (addrb/enb/doutb).
- Accepts one RV32I load or store at a time and drives port B for reads with 1-cycle latency.
- Handles sub-word stores as its own read-merge-write, then writes full words only. Formats load data with sign/zero extension.
- Flags misaligned and illegal-size accesses without touching memory.

Parameters:
- ADDR_W, 15, memory word-address width; word index = req_addr[ADDR_W+1:2].
- DATA_W, 32, data width; fixed at 32 for RV32.

Ports:
- clk  in  1  single clock; drives the memory clocks on both ports.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3; valid with resp_valid.
- mem_addra  out  ADDR_W  write word address.
- mem_dina  out  32  write data (always the full merged word).
- mem_ena  out  1  write enable, port A.
- mem_wea  out  4  byte enables; always 4'b1111 whenever mem_ena=1.
- mem_addrb  out  ADDR_W  read word address.
- mem_enb  out  1  read enable, port B.
- mem_doutb  in  32  read data; valid the cycle after mem_enb.

Behaviour:
- Reset:
  - State IDLE.
  - req_ready=0 while rst=1, 1 the cycle after reset is released.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_ena=0, mem_enb=0, mem_wea=0, mem_addra=0, mem_addrb=0, mem_dina=0.
  - mem_ena and mem_enb are gated by !rst: no memory access occurs in any cycle with rst=1.
  - Reset mid-operation aborts the operation; no write and no response is issued for it.
- Handshake:
  - Accept occurs on a clock edge with req_valid & req_ready. req_ready=1 only in IDLE.
  - Request fields are latched at accept; later changes to the inputs are ignored.
- Error check at accept:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores 011..111.
  - On error, go to RESP with resp_err=1 and resp_rdata=0. No memory enable is asserted.
- mem_ena and mem_enb are never high in the same cycle.
- States: IDLE, RD, MERGE, LDFMT, WR, RESP.
- Load (accept edge = cycle 0):
  - RD (cycle 1): mem_enb=1, mem_addrb=word index.
  - LDFMT (cycle 2): mem_doutb valid. Select the byte/half lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Register the result.
  - RESP (cycle 3): resp_valid=1, resp_rdata = formatted value.
  - Total: response in cycle 3 after accept.
- SW:
  - WR (cycle 1): mem_ena=1, mem_wea=1111, mem_dina=req_wdata.
  - RESP in cycle 2.
- SB/SH:
  - RD (cycle 1): read the target word.
  - MERGE (cycle 2): replace the addressed lane(s) of mem_doutb with req_wdata[7:0] or [15:0]; register the merged word.
  - WR (cycle 3): full-word write of the merged word.
  - RESP in cycle 4.
- RESP always returns to IDLE; req_ready=1 again the next cycle.
- Maximum sustained rate: one load every 4 cycles.
- resp_rdata and resp_err hold their values until the next RESP; resp_valid is a single-cycle pulse with no backpressure.
- Address bits above ADDR_W+1 are ignored; addresses wrap modulo the memory size.

Test Plan:
- Reset:
  - Stimulus: drive rst=1 for 3 cycles with req_valid=1.
  - Required: req_ready=0, mem_ena=0 and mem_enb=0 throughout; no resp_valid.
- SW then LW:
  - Stimulus: SW addr 0x0000_0010, data 0xDEADBEEF; then LW from the same address.
  - Required: mem_ena pulses once with addra=4, wea=1111, dina=0xDEADBEEF; store resp in cycle 2; load resp in cycle 3 with resp_rdata=0xDEADBEEF, resp_err=0.
- SB/SH merge:
  - Stimulus: SB 0x5A to addr 0x11, then SH 0x1234 to addr 0x12, over the word 0xDEADBEEF.
  - Required: LW at 0x10 returns 0x12345AEF; each sub-word store responds in cycle 4 and writes exactly one full word.
- Load extension on word 0x12345AEF:
  - LB@0x10 = 0xFFFFFFEF; LBU@0x10 = 0x000000EF; LH@0x12 = 0x00001234; LHU@0x10 = 0x00005AEF.
- Errors:
  - LW@0x12, SH@0x13, and funct3=011 load.
  - Required: each gives resp_err=1 in cycle 1 after accept and resp_rdata=0; mem_ena and mem_enb stay 0.
- Reset during SB:
  - Stimulus: assert rst in cycle 2 (MERGE) of an SB.
  - Required: no mem_ena pulse and no resp_valid; a subsequent LW returns the original word unchanged.
